l2_reqs_buf_ctrl: RTL and testbench

Parametrised ongoing-transaction buffer (MSHR) for the L2 controller, the successor to the fixed single-format reqs_buf_t array. It holds N_REQS in-flight CPU requests, each with tag/set/way, unstable state, signed invalidation-ack counter and an opaque payload. It provides per-cycle allocate, state update, invack accounting and free. It performs fully-associative line lookup and set-conflict detection for the L2 input arbiter.

---
 rtl/l2_reqs_buf_ctrl.sv | 149 ++++++++++++++
 tb/tb_l2_reqs_buf_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_reqs_buf_ctrl.sv
// Ongoing-transaction buffer (MSHR) for the L2 controller: N_REQS in-flight requests with
// allocate/update/invack/free ports, fully-associative line lookup and set-conflict detection.
module l2_reqs_buf_ctrl #(
    parameter int N_REQS       = 4,
    parameter int TAG_BITS     = 15,
    parameter int SET_BITS     = 9,
    parameter int WAY_BITS     = 3,
    parameter int STATE_BITS   = 4,
    parameter int INVACK_BITS  = 5,
    parameter int PAYLOAD_BITS = 128,
    localparam int IDX_BITS    = $clog2(N_REQS)
) (
    input  logic                    clk,
    input  logic                    rst,
    // alloc handshake: an entry is written at a posedge where alloc_valid && alloc_ready;
    // alloc_ready depends only on registered state, never on alloc_valid.
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [TAG_BITS-1:0]     alloc_tag,
    input  logic [SET_BITS-1:0]     alloc_set,
    input  logic [WAY_BITS-1:0]     alloc_way,
    input  logic [STATE_BITS-1:0]   alloc_state,
    input  logic [PAYLOAD_BITS-1:0] alloc_payload,
    output logic [IDX_BITS-1:0]     alloc_idx,
    input  logic                    upd_valid,
    input  logic [IDX_BITS-1:0]     upd_idx,
    input  logic [STATE_BITS-1:0]   upd_state,
    input  logic                    invdec_valid,
    input  logic [IDX_BITS-1:0]     invdec_idx,
    input  logic                    invadd_valid,
    input  logic [IDX_BITS-1:0]     invadd_idx,
    input  logic [INVACK_BITS-1:0]  invadd_val,
    input  logic                    free_valid,
    input  logic [IDX_BITS-1:0]     free_idx,
    input  logic [TAG_BITS-1:0]     lkp_tag,
    input  logic [SET_BITS-1:0]     lkp_set,
    output logic                    lkp_hit,
    output logic [IDX_BITS-1:0]     lkp_idx,
    output logic                    set_conflict,
    output logic [IDX_BITS-1:0]     set_conflict_idx,
    input  logic [IDX_BITS-1:0]     rd_idx,
    output logic                    rd_valid,
    output logic [TAG_BITS-1:0]     rd_tag,
    output logic [SET_BITS-1:0]     rd_set,
    output logic [WAY_BITS-1:0]     rd_way,
    output logic [STATE_BITS-1:0]   rd_state,
    output logic [INVACK_BITS-1:0]  rd_invack,
    output logic [PAYLOAD_BITS-1:0] rd_payload,
    output logic [N_REQS-1:0]       invack_zero,
    output logic [IDX_BITS:0]       count,
    output logic                    empty,
    output logic                    full
);

    logic [N_REQS-1:0]       valid_q;
    logic [TAG_BITS-1:0]     tag_q     [N_REQS];
    logic [SET_BITS-1:0]     set_q     [N_REQS];
    logic [WAY_BITS-1:0]     way_q     [N_REQS];
    logic [STATE_BITS-1:0]   state_q   [N_REQS];
    logic [INVACK_BITS-1:0]  invack_q  [N_REQS];
    logic [PAYLOAD_BITS-1:0] payload_q [N_REQS];

    logic [N_REQS-1:0]       free_hit;
    logic [N_REQS-1:0]       upd_hit;
    logic [N_REQS-1:0]       inv_hit;
    logic [INVACK_BITS-1:0]  inv_next  [N_REQS];
    logic                    alloc_fire;

    // Status, alloc slot select (lowest free index), lookup (lowest match wins by downward scan).
    always_comb begin
        count            = '0;
        alloc_idx        = '0;
        lkp_hit          = 1'b0;
        lkp_idx          = '0;
        set_conflict     = 1'b0;
        set_conflict_idx = '0;
        for (int i = N_REQS - 1; i >= 0; i--) begin
            count = count + (IDX_BITS + 1)'(valid_q[i]);
            if (!valid_q[i]) alloc_idx = IDX_BITS'(i);
            if (valid_q[i] && set_q[i] == lkp_set) begin
                set_conflict     = 1'b1;
                set_conflict_idx = IDX_BITS'(i);
                if (tag_q[i] == lkp_tag) begin
                    lkp_hit = 1'b1;
                    lkp_idx = IDX_BITS'(i);
                end
            end
        end
    end

    assign full        = (count == (IDX_BITS + 1)'(N_REQS));
    assign empty       = (count == '0);
    assign alloc_ready = !full;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Per-entry write enables; a free in the same cycle masks state and invack updates.
    always_comb begin
        for (int i = 0; i < N_REQS; i++) begin
            free_hit[i]    = free_valid && free_idx == IDX_BITS'(i) && valid_q[i];
            upd_hit[i]     = upd_valid && upd_idx == IDX_BITS'(i) && valid_q[i] && !free_hit[i];
            inv_hit[i]     = valid_q[i] && !free_hit[i] &&
                             ((invdec_valid && invdec_idx == IDX_BITS'(i)) ||
                              (invadd_valid && invadd_idx == IDX_BITS'(i)));
            inv_next[i]    = invack_q[i]
                           - ((invdec_valid && invdec_idx == IDX_BITS'(i)) ? INVACK_BITS'(1) : '0)
                           + ((invadd_valid && invadd_idx == IDX_BITS'(i)) ? invadd_val : '0);
            invack_zero[i] = valid_q[i] && invack_q[i] == '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < N_REQS; i++) begin
                tag_q[i]     <= '0;
                set_q[i]     <= '0;
                way_q[i]     <= '0;
                state_q[i]   <= '0;
                invack_q[i]  <= '0;
                payload_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQS; i++) begin
                if (free_hit[i]) valid_q[i] <= 1'b0;
                if (upd_hit[i])  state_q[i] <= upd_state;
                if (inv_hit[i])  invack_q[i] <= inv_next[i];
            end
            // alloc_idx always names an invalid entry, so it never collides with the hits above.
            if (alloc_fire) begin
                valid_q[alloc_idx]   <= 1'b1;
                tag_q[alloc_idx]     <= alloc_tag;
                set_q[alloc_idx]     <= alloc_set;
                way_q[alloc_idx]     <= alloc_way;
                state_q[alloc_idx]   <= alloc_state;
                invack_q[alloc_idx]  <= '0;
                payload_q[alloc_idx] <= alloc_payload;
            end
        end
    end

    assign rd_valid   = valid_q[rd_idx];
    assign rd_tag     = tag_q[rd_idx];
    assign rd_set     = set_q[rd_idx];
    assign rd_way     = way_q[rd_idx];
    assign rd_state   = state_q[rd_idx];
    assign rd_invack  = invack_q[rd_idx];
    assign rd_payload = payload_q[rd_idx];

endmodule

// File: tb/tb_l2_reqs_buf_ctrl.sv
// Self-checking bench for l2_reqs_buf_ctrl: directed scenarios with a tag/payload scoreboard.
module tb_l2_reqs_buf_ctrl;
    localparam int N = 4, TB = 15, SB = 9, WB = 3, STB = 4, IB = 5, PB = 128, XB = 2;

    logic clk = 1'b0;
    logic rst;
    logic alloc_valid, alloc_ready;
    logic [TB-1:0] alloc_tag;
    logic [SB-1:0] alloc_set;
    logic [WB-1:0] alloc_way;
    logic [STB-1:0] alloc_state;
    logic [PB-1:0] alloc_payload;
    logic [XB-1:0] alloc_idx;
    logic upd_valid;
    logic [XB-1:0] upd_idx;
    logic [STB-1:0] upd_state;
    logic invdec_valid;
    logic [XB-1:0] invdec_idx;
    logic invadd_valid;
    logic [XB-1:0] invadd_idx;
    logic [IB-1:0] invadd_val;
    logic free_valid;
    logic [XB-1:0] free_idx;
    logic [TB-1:0] lkp_tag;
    logic [SB-1:0] lkp_set;
    logic lkp_hit, set_conflict;
    logic [XB-1:0] lkp_idx, set_conflict_idx, rd_idx;
    logic rd_valid;
    logic [TB-1:0] rd_tag;
    logic [SB-1:0] rd_set;
    logic [WB-1:0] rd_way;
    logic [STB-1:0] rd_state;
    logic [IB-1:0] rd_invack;
    logic [PB-1:0] rd_payload;
    logic [N-1:0] invack_zero;
    logic [XB:0] count;
    logic empty, full;

    int tests_run = 0;
    int tests_failed = 0;
    logic [TB+PB-1:0] exp_q[$];

    l2_reqs_buf_ctrl dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_set(alloc_set), .alloc_way(alloc_way), .alloc_state(alloc_state),
        .alloc_payload(alloc_payload), .alloc_idx(alloc_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_state(upd_state),
        .invdec_valid(invdec_valid), .invdec_idx(invdec_idx),
        .invadd_valid(invadd_valid), .invadd_idx(invadd_idx), .invadd_val(invadd_val),
        .free_valid(free_valid), .free_idx(free_idx),
        .lkp_tag(lkp_tag), .lkp_set(lkp_set), .lkp_hit(lkp_hit), .lkp_idx(lkp_idx),
        .set_conflict(set_conflict), .set_conflict_idx(set_conflict_idx),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_set(rd_set),
        .rd_way(rd_way), .rd_state(rd_state), .rd_invack(rd_invack), .rd_payload(rd_payload),
        .invack_zero(invack_zero), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the active edge; checks happen 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_tag = '0; alloc_set = '0; alloc_way = '0; alloc_state = '0;
        alloc_payload = '0; upd_valid = 0; upd_idx = '0; upd_state = '0;
        invdec_valid = 0; invdec_idx = '0; invadd_valid = 0; invadd_idx = '0; invadd_val = '0;
        free_valid = 0; free_idx = '0; lkp_tag = '0; lkp_set = '0; rd_idx = '0;
    endtask

    task automatic drive_alloc(input logic [TB-1:0] t, input logic [SB-1:0] s,
                               input logic [WB-1:0] w, input logic [STB-1:0] st,
                               input logic [PB-1:0] p);
        alloc_valid = 1; alloc_tag = t; alloc_set = s; alloc_way = w; alloc_state = st;
        alloc_payload = p;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        repeat (3) @(posedge clk);
        #3 rst = 1;
        #1;
        tests_run++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin tests_failed++;
            $display("FAIL reset_status: count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
        tests_run++; if (alloc_ready !== 1'b1 || alloc_idx !== 2'd0) begin tests_failed++;
            $display("FAIL reset_alloc: ready=%b idx=%0d want 1/0", alloc_ready, alloc_idx); end
        tests_run++; if (lkp_hit !== 1'b0 || set_conflict !== 1'b0 || invack_zero !== 4'b0 || rd_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_lkp: hit=%b sc=%b iz=%b rdv=%b want all 0",
                lkp_hit, set_conflict, invack_zero, rd_valid); end
    endtask

    task automatic test_fill();
        logic [PB-1:0] p;
        logic [TB-1:0] et;
        logic [PB-1:0] ep;
        step();
        for (int k = 0; k < N; k++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            drive_alloc(TB'(16 + k), 9'd5, WB'(k), STB'(k), p);
            exp_q.push_back({TB'(16 + k), p});
            #1;
            tests_run++; if (alloc_ready !== 1'b1 || alloc_idx !== XB'(k)) begin tests_failed++;
                $display("FAIL fill_idx%0d: ready=%b idx=%0d want 1/%0d", k, alloc_ready, alloc_idx, k); end
            step();
        end
        alloc_valid = 0;
        #1;
        tests_run++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 3'd4) begin tests_failed++;
            $display("FAIL fill_full: full=%b ready=%b count=%0d want 1/0/4", full, alloc_ready, count); end
        drive_alloc(15'h99, 9'd5, 3'd0, 4'd0, '1);
        step();
        alloc_valid = 0;
        #1;
        tests_run++; if (count !== 3'd4) begin tests_failed++;
            $display("FAIL fill_overflow_count: got %0d want 4", count); end
        for (int i = 0; i < N; i++) begin
            rd_idx = XB'(i);
            #1;
            {et, ep} = exp_q.pop_front();
            tests_run++; if (rd_valid !== 1'b1 || rd_tag !== et || rd_payload !== ep || rd_set !== 9'd5 || rd_way !== WB'(i)) begin
                tests_failed++; $display("FAIL fill_entry%0d: v=%b tag=%h set=%0d way=%0d want 1/%h/5/%0d",
                    i, rd_valid, rd_tag, rd_set, rd_way, et, i); end
        end
    endtask

    task automatic test_full_alloc_free();
        step();
        free_valid = 1; free_idx = 2'd2;
        drive_alloc(15'h55, 9'd3, 3'd1, 4'd1, '0);
        #1;
        tests_run++; if (alloc_ready !== 1'b0) begin tests_failed++;
            $display("FAIL fullfree_blocked: ready=%b want 0", alloc_ready); end
        step();
        idle();
        #1;
        tests_run++; if (full !== 1'b0 || alloc_idx !== 2'd2 || count !== 3'd3) begin tests_failed++;
            $display("FAIL fullfree_after: full=%b idx=%0d count=%0d want 0/2/3", full, alloc_idx, count); end
        drive_alloc(15'h22, 9'd9, 3'd2, 4'd2, 128'hABCD);
        step();
        idle();
        rd_idx = 2'd2;
        #1;
        tests_run++; if (count !== 3'd4 || rd_tag !== 15'h22 || rd_payload !== 128'hABCD) begin tests_failed++;
            $display("FAIL fullfree_realloc: count=%0d tag=%h want 4/22", count, rd_tag); end
    endtask

    task automatic test_lookup();
        free_valid = 1; free_idx = 2'd1;
        step();
        idle();
        drive_alloc(15'h20, 9'd7, 3'd4, 4'd1, '0);
        #1;
        tests_run++; if (alloc_idx !== 2'd1) begin tests_failed++;
            $display("FAIL lkp_alloc_idx: got %0d want 1", alloc_idx); end
        step();
        idle();
        lkp_tag = 15'h20; lkp_set = 9'd7; #1;
        tests_run++; if (lkp_hit !== 1'b1 || lkp_idx !== 2'd1 || set_conflict !== 1'b1 || set_conflict_idx !== 2'd1) begin
            tests_failed++; $display("FAIL lkp_hit: hit=%b idx=%0d sc=%b scidx=%0d want 1/1/1/1",
                lkp_hit, lkp_idx, set_conflict, set_conflict_idx); end
        lkp_tag = 15'h21; #1;
        tests_run++; if (lkp_hit !== 1'b0 || set_conflict !== 1'b1 || set_conflict_idx !== 2'd1) begin
            tests_failed++; $display("FAIL lkp_conflict: hit=%b sc=%b scidx=%0d want 0/1/1",
                lkp_hit, set_conflict, set_conflict_idx); end
        lkp_tag = 15'h20; lkp_set = 9'd8; #1;
        tests_run++; if (lkp_hit !== 1'b0 || set_conflict !== 1'b0) begin tests_failed++;
            $display("FAIL lkp_miss: hit=%b sc=%b want 0/0", lkp_hit, set_conflict); end
        lkp_tag = 15'h13; lkp_set = 9'd5; #1;
        tests_run++; if (lkp_hit !== 1'b1 || lkp_idx !== 2'd3 || set_conflict_idx !== 2'd0) begin tests_failed++;
            $display("FAIL lkp_lowest: hit=%b idx=%0d scidx=%0d want 1/3/0", lkp_hit, lkp_idx, set_conflict_idx); end
    endtask

    task automatic test_invack();
        idle(); #1;
        tests_run++; if (invack_zero !== 4'hF) begin tests_failed++;
            $display("FAIL inv_zero_init: got %b want 1111", invack_zero); end
        invadd_valid = 1; invadd_idx = 2'd0; invadd_val = 5'd3;
        step();
        idle(); #1;
        tests_run++; if (rd_invack !== 5'd3 || invack_zero[0] !== 1'b0) begin tests_failed++;
            $display("FAIL inv_add3: inv=%h iz0=%b want 03/0", rd_invack, invack_zero[0]); end
        invdec_valid = 1; invdec_idx = 2'd0; invadd_valid = 1; invadd_idx = 2'd0; invadd_val = 5'h1E;
        step();
        idle(); #1;
        tests_run++; if (rd_invack !== 5'd0 || invack_zero[0] !== 1'b1) begin tests_failed++;
            $display("FAIL inv_dec_add: inv=%h iz0=%b want 00/1", rd_invack, invack_zero[0]); end
        invdec_valid = 1; invdec_idx = 2'd0;
        step();
        idle(); #1;
        tests_run++; if (rd_invack !== 5'h1F || invack_zero[0] !== 1'b0) begin tests_failed++;
            $display("FAIL inv_wrap: inv=%h iz0=%b want 1f/0", rd_invack, invack_zero[0]); end
        invdec_valid = 1; invdec_idx = 2'd2; invadd_valid = 1; invadd_idx = 2'd3; invadd_val = 5'd4;
        step();
        idle();
        rd_idx = 2'd2; #1;
        tests_run++; if (rd_invack !== 5'h1F) begin tests_failed++;
            $display("FAIL inv_indep2: got %h want 1f", rd_invack); end
        rd_idx = 2'd3; #1;
        tests_run++; if (rd_invack !== 5'd4 || invack_zero !== 4'b0010) begin tests_failed++;
            $display("FAIL inv_indep3: inv=%h iz=%b want 04/0010", rd_invack, invack_zero); end
    endtask

    task automatic test_upd_free();
        upd_valid = 1; upd_idx = 2'd3; upd_state = 4'd9; free_valid = 1; free_idx = 2'd3;
        step();
        idle();
        rd_idx = 2'd3; #1;
        tests_run++; if (rd_valid !== 1'b0 || count !== 3'd3) begin tests_failed++;
            $display("FAIL updfree_same: v=%b count=%0d want 0/3", rd_valid, count); end
        upd_valid = 1; upd_idx = 2'd3; upd_state = 4'hA;
        invadd_valid = 1; invadd_idx = 2'd3; invadd_val = 5'd5;
        free_valid = 1; free_idx = 2'd3;
        step();
        idle();
        rd_idx = 2'd3; #1;
        tests_run++; if (rd_state !== 4'd3 || rd_invack !== 5'd4 || rd_valid !== 1'b0 || count !== 3'd3) begin
            tests_failed++; $display("FAIL updfree_invalid: st=%0d inv=%h v=%b count=%0d want 3/04/0/3",
                rd_state, rd_invack, rd_valid, count); end
        upd_valid = 1; upd_idx = 2'd2; upd_state = 4'hC;
        step();
        idle();
        rd_idx = 2'd2; #1;
        tests_run++; if (rd_state !== 4'hC || rd_valid !== 1'b1) begin tests_failed++;
            $display("FAIL upd_valid_entry: st=%h v=%b want c/1", rd_state, rd_valid); end
    endtask

    task automatic test_async_reset();
        lkp_tag = 15'h20; lkp_set = 9'd7; #1;
        tests_run++; if (lkp_hit !== 1'b1 || count !== 3'd3) begin tests_failed++;
            $display("FAIL arst_pre: hit=%b count=%0d want 1/3", lkp_hit, count); end
        invdec_valid = 1; invdec_idx = 2'd0;
        step();
        rst = 0;
        #1;
        tests_run++; if (empty !== 1'b1 || count !== 3'd0 || lkp_hit !== 1'b0) begin tests_failed++;
            $display("FAIL arst_immediate: empty=%b count=%0d hit=%b want 1/0/0", empty, count, lkp_hit); end
        #2 idle();
        rst = 1;
        #1;
        tests_run++; if (alloc_idx !== 2'd0) begin tests_failed++;
            $display("FAIL arst_alloc_idx: got %0d want 0", alloc_idx); end
        drive_alloc(15'h7, 9'd1, 3'd0, 4'd2, 128'h5);
        step();
        idle(); #1;
        tests_run++; if (count !== 3'd1 || rd_valid !== 1'b1 || rd_tag !== 15'h7 || rd_invack !== 5'd0) begin
            tests_failed++; $display("FAIL arst_first_alloc: count=%0d v=%b tag=%h inv=%h want 1/1/7/00",
                count, rd_valid, rd_tag, rd_invack); end
    endtask

    task automatic test_back_to_back();
        drive_alloc(15'h8, 9'd2, 3'd1, 4'd3, 128'h6);
        free_valid = 1; free_idx = 2'd0;
        step();
        idle(); #1;
        tests_run++; if (count !== 3'd1 || rd_valid !== 1'b0 || alloc_idx !== 2'd0) begin tests_failed++;
            $display("FAIL b2b_count: count=%0d v0=%b aidx=%0d want 1/0/0", count, rd_valid, alloc_idx); end
        rd_idx = 2'd1; #1;
        tests_run++; if (rd_valid !== 1'b1 || rd_tag !== 15'h8) begin tests_failed++;
            $display("FAIL b2b_entry1: v=%b tag=%h want 1/8", rd_valid, rd_tag); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_alloc_free();
        test_lookup();
        test_invack();
        test_upd_free();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
